// File: rtl/bist_scheduler.sv
// rtl/bist_scheduler.sv - round-robin owner arbitration and session sequencing for a shared BIST engine
module bist_scheduler #(
  parameter int TIMEOUT = 1200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] REQ,
  input  logic       FINISH,
  input  logic       BIST_END,
  input  logic       SIG_OK,
  output logic       START,
  output logic [2:0] GRANT,
  output logic [2:0] DONE,
  output logic [2:0] PASS,
  output logic       ERR
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARB      = 3'd1,
    LAUNCH   = 3'd2,
    WAIT_FIN = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  localparam logic [10:0] WDOG_LIMIT = 11'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [10:0] wdog;
  logic [1:0]  last_ptr;
  logic [1:0]  owner_idx;
  logic [2:0]  arb_pick;
  logic        load_grant;
  logic        fin_evt;
  logic        to_evt;

  // BIST_END is a status-only flag with no consumer inside this block
  logic unused_inputs;
  assign unused_inputs = BIST_END;

  // Round-robin pick: search begins one past the last granted index
  always_comb begin
    arb_pick = 3'b000;
    case (last_ptr)
      2'd0: begin
        if      (REQ[1]) arb_pick = 3'b010;
        else if (REQ[2]) arb_pick = 3'b100;
        else if (REQ[0]) arb_pick = 3'b001;
      end
      2'd1: begin
        if      (REQ[2]) arb_pick = 3'b100;
        else if (REQ[0]) arb_pick = 3'b001;
        else if (REQ[1]) arb_pick = 3'b010;
      end
      default: begin
        if      (REQ[0]) arb_pick = 3'b001;
        else if (REQ[1]) arb_pick = 3'b010;
        else if (REQ[2]) arb_pick = 3'b100;
      end
    endcase
  end

  // Binary index of the current one-hot owner
  always_comb begin
    owner_idx = 2'd0;
    if      (GRANT[1]) owner_idx = 2'd1;
    else if (GRANT[2]) owner_idx = 2'd2;
  end

  // State register, asynchronously forced to IDLE by RESET
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and decoded outputs; START and DONE come only from state and GRANT
  always_comb begin
    state_nxt  = state;
    START      = 1'b0;
    DONE       = 3'b000;
    load_grant = 1'b0;
    fin_evt    = 1'b0;
    to_evt     = 1'b0;
    case (state)
      IDLE: begin
        if (REQ != 3'b000) state_nxt = ARB;
      end
      ARB: begin
        if (REQ == 3'b000) begin
          state_nxt = IDLE;
        end else begin
          load_grant = 1'b1;
          state_nxt  = LAUNCH;
        end
      end
      LAUNCH: begin
        START     = 1'b1;
        state_nxt = WAIT_FIN;
      end
      WAIT_FIN: begin
        START = 1'b1;
        // FINISH wins over a coincident timeout
        if (FINISH) begin
          fin_evt   = 1'b1;
          state_nxt = RELEASE;
        end else if (wdog == WDOG_LIMIT) begin
          to_evt    = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        DONE      = GRANT;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, pointer, watchdog and sticky result registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      GRANT    <= 3'b000;
      PASS     <= 3'b000;
      ERR      <= 1'b0;
      wdog     <= 11'd0;
      last_ptr <= 2'd2;
    end else begin
      if (load_grant) GRANT <= arb_pick;
      if (state == RELEASE) begin
        GRANT    <= 3'b000;
        last_ptr <= owner_idx;
      end
      if (state == LAUNCH)        wdog <= 11'd0;
      else if (state == WAIT_FIN) wdog <= wdog + 11'd1;
      if (fin_evt) begin
        PASS <= (PASS & ~GRANT) | (GRANT & {3{SIG_OK}});
      end else if (to_evt) begin
        PASS <= PASS & ~GRANT;
        ERR  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bist_scheduler.sv
// tb/tb_bist_scheduler.sv - directed self-checking bench for bist_scheduler
module tb_bist_scheduler;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [2:0] REQ;
  logic       FINISH;
  logic       BIST_END;
  logic       SIG_OK;
  logic       START;
  logic [2:0] GRANT;
  logic [2:0] DONE;
  logic [2:0] PASS;
  logic       ERR;

  int n_tests = 0;
  int n_fail  = 0;

  bist_scheduler #(.TIMEOUT(1200)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .FINISH(FINISH), .BIST_END(BIST_END),
    .SIG_OK(SIG_OK), .START(START), .GRANT(GRANT), .DONE(DONE), .PASS(PASS), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Advance until LAUNCH (START rises) and check the grant owner
  task automatic wait_launch(input string tag, input logic [2:0] exp_grant);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step(1);
      if (START === 1'b1) seen = 1'b1;
    end
    check({tag, "_launch_seen"}, {7'd0, seen}, 8'd1);
    check({tag, "_grant"}, {5'd0, GRANT}, {5'd0, exp_grant});
  endtask

  // From LAUNCH, pulse FINISH during WAIT_FIN cycle n, ending in RELEASE
  task automatic finish_at(input int n, input logic ok);
    step(n + 1);
    FINISH = 1'b1;
    SIG_OK = ok;
    step(1);
    FINISH = 1'b0;
    SIG_OK = 1'b0;
  endtask

  // Checks in RELEASE and the following IDLE cycle
  task automatic check_release(input string tag, input logic [2:0] exp_done,
                               input logic [2:0] exp_pass, input logic exp_err);
    check({tag, "_rel_start"}, {7'd0, START}, 8'd0);
    check({tag, "_rel_done"}, {5'd0, DONE}, {5'd0, exp_done});
    check({tag, "_rel_pass"}, {5'd0, PASS}, {5'd0, exp_pass});
    check({tag, "_rel_err"}, {7'd0, ERR}, {7'd0, exp_err});
    step(1);
    check({tag, "_idle_start"}, {7'd0, START}, 8'd0);
    check({tag, "_idle_done"}, {5'd0, DONE}, 8'd0);
    check({tag, "_idle_grant"}, {5'd0, GRANT}, 8'd0);
  endtask

  initial begin
    RESET = 1'b1; REQ = 3'b000; FINISH = 1'b0; BIST_END = 1'b0; SIG_OK = 1'b0;
    step(2);
    check("rst_start", {7'd0, START}, 8'd0);
    check("rst_grant", {5'd0, GRANT}, 8'd0);
    check("rst_done", {5'd0, DONE}, 8'd0);
    check("rst_pass", {5'd0, PASS}, 8'd0);
    check("rst_err", {7'd0, ERR}, 8'd0);
    RESET = 1'b0;
    step(2);
    check("idle_no_req_start", {7'd0, START}, 8'd0);

    // FINISH outside WAIT_FIN is ignored
    FINISH = 1'b1; SIG_OK = 1'b1; BIST_END = 1'b1;
    step(1);
    FINISH = 1'b0; SIG_OK = 1'b0; BIST_END = 1'b0;
    check("stray_finish_pass", {5'd0, PASS}, 8'd0);

    // Single request, finish at WAIT_FIN cycle 1010 with good signature
    REQ = 3'b001;
    wait_launch("single", 3'b001);
    finish_at(1010, 1'b1);
    REQ = 3'b000;
    check_release("single", 3'b001, 3'b001, 1'b0);

    // Round robin with all requesters held
    REQ = 3'b111;
    wait_launch("rr1", 3'b010);
    finish_at(2, 1'b1);
    check_release("rr1", 3'b010, 3'b011, 1'b0);
    wait_launch("rr2", 3'b100);
    finish_at(2, 1'b1);
    check_release("rr2", 3'b100, 3'b111, 1'b0);
    wait_launch("rr3", 3'b001);
    finish_at(2, 1'b1);
    REQ = 3'b000;
    check_release("rr3", 3'b001, 3'b111, 1'b0);

    // Failing signature only touches the owner's PASS bit
    REQ = 3'b010;
    wait_launch("fail", 3'b010);
    finish_at(5, 1'b0);
    REQ = 3'b000;
    check_release("fail", 3'b010, 3'b101, 1'b0);

    // REQ dropped mid-session, FINISH coincides with the timeout cycle
    REQ = 3'b001;
    wait_launch("simul", 3'b001);
    REQ = 3'b000;
    finish_at(1199, 1'b1);
    check_release("simul", 3'b001, 3'b101, 1'b0);

    // Watchdog timeout: still in WAIT_FIN on cycle 1199, RELEASE next
    REQ = 3'b100;
    wait_launch("tmo", 3'b100);
    REQ = 3'b000;
    step(1200);
    check("tmo_last_wait_start", {7'd0, START}, 8'd1);
    check("tmo_last_wait_err", {7'd0, ERR}, 8'd0);
    step(1);
    check_release("tmo", 3'b100, 3'b001, 1'b1);
    step(3);
    check("tmo_err_sticky", {7'd0, ERR}, 8'd1);

    // Asynchronous reset in WAIT_FIN aborts without DONE
    REQ = 3'b010;
    wait_launch("rstmid", 3'b010);
    step(4);
    #2 RESET = 1'b1;
    #1;
    check("rstmid_start", {7'd0, START}, 8'd0);
    check("rstmid_grant", {5'd0, GRANT}, 8'd0);
    check("rstmid_done", {5'd0, DONE}, 8'd0);
    check("rstmid_pass", {5'd0, PASS}, 8'd0);
    check("rstmid_err", {7'd0, ERR}, 8'd0);
    REQ = 3'b111;
    step(1);
    RESET = 1'b0;
    step(1);
    check("post_rst_start", {7'd0, START}, 8'd0);
    check("post_rst_done", {5'd0, DONE}, 8'd0);
    wait_launch("post_rst", 3'b001);
    REQ = 3'b000;
    finish_at(0, 1'b1);
    check_release("post_rst", 3'b001, 3'b001, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
